// File: rtl/shared_gate_pkg.sv
// Shared types for the shared gate arbiter.
// Optional per-request op select is enabled by GATE_OP_SEL_EN.
package shared_gate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

endpackage

// File: rtl/shared_gate_arbiter_rr.sv
// Combinational round-robin arbiter.
// Search starts one past ptr; lowest distance wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any_req
);

  function automatic int wrap(input int p, input int k);
    return (p + k) % N_REQ;
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_req = |req;
    // Walk farthest-first so the nearest match is the last write.
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[ID_W'(wrap(int'(ptr), k))]) begin
        gnt     = '0;
        gnt[ID_W'(wrap(int'(ptr), k))] = 1'b1;
        gnt_idx = ID_W'(wrap(int'(ptr), k));
      end
    end
  end

endmodule

// File: rtl/shared_gate_arbiter.sv
// One registered bitwise gate shared by N_REQ requesters.
// Define GATE_OP_SEL_EN to add per-request op select (req_op).
module shared_gate_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
`ifdef GATE_OP_SEL_EN
  input  logic [N_REQ*2-1:0]     req_op,
`endif
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id
);
  import shared_gate_pkg::*;

  state_t           r_state;
  state_t           w_next;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id_q;
  logic [WIDTH-1:0] r_a_q;
  logic [WIDTH-1:0] r_b_q;
  logic [WIDTH-1:0] r_rsp_data;
  logic [ID_W-1:0]  r_rsp_id;
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_any;
  logic             w_xfer;
  logic [WIDTH-1:0] w_res;
`ifdef GATE_OP_SEL_EN
  logic [1:0]       r_op_q;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any_req (w_any)
  );

  assign req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign w_xfer    = (r_state == IDLE) && w_any;
  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

  always_comb begin
    w_res = r_a_q & r_b_q;
`ifdef GATE_OP_SEL_EN
    unique case (r_op_q)
      OP_AND:  w_res = r_a_q & r_b_q;
      OP_OR:   w_res = r_a_q | r_b_q;
      OP_XOR:  w_res = r_a_q ^ r_b_q;
      OP_NAND: w_res = ~(r_a_q & r_b_q);
      default: w_res = r_a_q & r_b_q;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= ID_W'(N_REQ - 1);
      r_id_q     <= '0;
      r_a_q      <= '0;
      r_b_q      <= '0;
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
`ifdef GATE_OP_SEL_EN
      r_op_q     <= OP_AND;
`endif
    end else begin
      if (w_xfer) begin
        r_ptr  <= w_gnt_idx;
        r_id_q <= w_gnt_idx;
        r_a_q  <= req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
        r_b_q  <= req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
`ifdef GATE_OP_SEL_EN
        r_op_q <= req_op[int'(w_gnt_idx)*2 +: 2];
`endif
      end
      if (r_state == EXEC) begin
        r_rsp_data <= w_res;
        r_rsp_id   <= r_id_q;
      end
    end
  end

endmodule

// File: tb/tb_shared_gate_arbiter.sv
// Directed bench for shared_gate_arbiter (4 requesters, 8-bit).
// Covers GATE_OP_SEL_EN when the macro is defined.
module tb_shared_gate_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic [7:0]  ta [4];
  logic [7:0]  tb [4];
`ifdef GATE_OP_SEL_EN
  logic [7:0]  req_op;
`endif

  int n_chk;
  int n_fail;

  logic [7:0] exp_d [4];

  assign req_a = {ta[3], ta[2], ta[1], ta[0]};
  assign req_b = {tb[3], tb[2], tb[1], tb[0]};

  shared_gate_arbiter #(
    .N_REQ (4),
    .WIDTH (8),
    .ID_W  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef GATE_OP_SEL_EN
    .req_op    (req_op),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ta[i] = 8'h00;
      tb[i] = 8'h00;
    end
`ifdef GATE_OP_SEL_EN
    req_op = 8'h00;
`endif
    tick();
    tick();
    check("rst_vld", 32'(rsp_valid), 32'h0);
    check("rst_dat", 32'(rsp_data), 32'h0);
    check("rst_id", 32'(rsp_id), 32'h0);
    check("rst_rdy", 32'(req_ready), 32'h0);
    rst = 1'b0;
    tick();

    // single request from requester 0
    ta[0] = 8'hF0;
    tb[0] = 8'h3C;
    req_valid = 4'b0001;
    #1 check("t1_rdy", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    #1 check("t1_rdy_exec", 32'(req_ready), 32'h0);
    check("t1_vld_exec", 32'(rsp_valid), 32'h0);
    tick();
    check("t1_vld", 32'(rsp_valid), 32'h1);
    check("t1_dat", 32'(rsp_data), 32'h30);
    check("t1_id", 32'(rsp_id), 32'h0);
    tick();
    check("t1_vld_done", 32'(rsp_valid), 32'h0);

    // all four requesters, fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ta[0] = 8'hFF; tb[0] = 8'h01; exp_d[0] = 8'h01;
    ta[1] = 8'hFF; tb[1] = 8'h02; exp_d[1] = 8'h02;
    ta[2] = 8'hF3; tb[2] = 8'h3F; exp_d[2] = 8'h33;
    ta[3] = 8'hA5; tb[3] = 8'h5A; exp_d[3] = 8'h00;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("t2_rdy%0d", k), 32'(req_ready),
               32'(4'b0001 << (k % 4)));
      tick();
      check($sformatf("t2_exec%0d", k), 32'(rsp_valid), 32'h0);
      tick();
      check($sformatf("t2_vld%0d", k), 32'(rsp_valid), 32'h1);
      check($sformatf("t2_id%0d", k), 32'(rsp_id), 32'(k % 4));
      check($sformatf("t2_dat%0d", k), 32'(rsp_data),
            32'(exp_d[k % 4]));
      tick();
    end

    // backpressure: grant 1 then stall 10 cycles
    rsp_ready = 1'b0;
    #1 check("t3_rdy", 32'(req_ready), 32'h2);
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      check($sformatf("t3_vld%0d", c), 32'(rsp_valid), 32'h1);
      check($sformatf("t3_dat%0d", c), 32'(rsp_data), 32'h02);
      check($sformatf("t3_id%0d", c), 32'(rsp_id), 32'h1);
      check($sformatf("t3_rdy%0d", c), 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("t3_vld_done", 32'(rsp_valid), 32'h0);
    check("t3_rdy_next", 32'(req_ready), 32'h4);
    req_valid = 4'b0000;
    #1 check("t3_rdy_drop", 32'(req_ready), 32'h0);

    // requester 2 withdraws while requester 1 is busy
    req_valid = 4'b0010;
    #1 check("t4_rdy1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0100;
    #1 check("t4_rdy_busy", 32'(req_ready), 32'h0);
    tick();
    req_valid = 4'b0000;
    #1 check("t4_id", 32'(rsp_id), 32'h1);
    tick();
    check("t4_vld0", 32'(rsp_valid), 32'h0);
    tick();
    tick();
    check("t4_vld1", 32'(rsp_valid), 32'h0);
    req_valid = 4'b1111;
    #1 check("t4_ptr", 32'(req_ready), 32'h4);
    req_valid = 4'b0000;

    // reset during EXEC
    ta[0] = 8'hFF;
    tb[0] = 8'h0F;
    req_valid = 4'b0001;
    #1 check("t5_rdy", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    rst = 1'b1;
    #1 check("t5_vld_rst", 32'(rsp_valid), 32'h0);
    tick();
    check("t5_vld_hold", 32'(rsp_valid), 32'h0);
    check("t5_dat_rst", 32'(rsp_data), 32'h0);
    rst = 1'b0;
    tick();
    check("t5_vld_after", 32'(rsp_valid), 32'h0);
    req_valid = 4'b1111;
    #1 check("t5_rdy_ptr", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    tick();
    check("t5_vld", 32'(rsp_valid), 32'h1);
    check("t5_dat", 32'(rsp_data), 32'h0F);
    check("t5_id", 32'(rsp_id), 32'h0);
    tick();

`ifdef GATE_OP_SEL_EN
    // XOR on requester 3, NAND on requester 1
    ta[3] = 8'hAA;
    tb[3] = 8'hFF;
    req_op = 8'b10_00_00_00;
    req_valid = 4'b1000;
    #1 check("t6_rdy", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    tick();
    check("t6_dat", 32'(rsp_data), 32'h55);
    check("t6_id", 32'(rsp_id), 32'h3);
    tick();
    ta[1] = 8'hF0;
    tb[1] = 8'h3C;
    req_op = 8'b00_00_11_00;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    tick();
    check("t6_nand", 32'(rsp_data), 32'hCF);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
